currency_note_collector: RTL and testbench

- Upstream feeder for the bill-payment FSM's cash path. Accepts physical note events from the note reader, decodes denomination codes and accumulates value against the bill amount.
- When the bill is covered, it presents a single currency_inserted rising edge with currency_amount to the payment FSM.
- Handles overpayment (change), cancel and inactivity timeout (refund).
- All amounts are in units of 5 so that every value fits 8 bits: 1000 = 200 units, 5 = 1 unit.

---
 rtl/currency_note_collector.sv | 144 ++++++++++++++
 tb/tb_currency_note_collector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/currency_note_collector.sv
// Cash-path front end: decodes note events, accumulates value in 5-units against the
// latched bill and reports settlement (with change) or a refund on cancel/timeout.
module currency_note_collector #(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       collect_start,
  input  logic [7:0] bill_amount,
  input  logic       note_valid,
  input  logic [3:0] note_code,
  input  logic       collect_cancel,
  output logic       currency_inserted,
  output logic [7:0] currency_amount,
  output logic [7:0] change_amount,
  output logic       refund_valid,
  output logic [8:0] refund_amount,
  output logic       note_reject,
  output logic       busy,
  output logic [8:0] collected_amount
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, COLLECT, SETTLE, REFUND} state_t;

  state_t        state;
  logic [7:0]    target;
  logic [TW-1:0] timeout_cnt;
  logic [HW-1:0] hold_cnt;

  logic [7:0] note_value;
  logic       code_ok;
  logic       accept;
  logic [8:0] note_sum;
  logic [7:0] change;

  always_comb begin
    note_value = 8'd0;
    code_ok    = 1'b1;
    case (note_code)
      4'b1000: note_value = 8'd200;
      4'b0100: note_value = 8'd100;
      4'b0010: note_value = 8'd20;
      4'b0001: note_value = 8'd10;
      4'b1010: note_value = 8'd4;
      4'b0110: note_value = 8'd2;
      4'b0000: note_value = 8'd1;
      default: code_ok    = 1'b0;
    endcase
    accept   = note_valid && code_ok;
    note_sum = collected_amount + (accept ? {1'b0, note_value} : 9'd0);
    // Overpayment is at most 199, so the low byte of the difference is exact.
    change   = note_sum[7:0] - target;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      target            <= 8'd0;
      timeout_cnt       <= '0;
      hold_cnt          <= '0;
      currency_inserted <= 1'b0;
      currency_amount   <= 8'd0;
      change_amount     <= 8'd0;
      refund_valid      <= 1'b0;
      refund_amount     <= 9'd0;
      note_reject       <= 1'b0;
      busy              <= 1'b0;
      collected_amount  <= 9'd0;
    end else begin
      note_reject  <= 1'b0;
      refund_valid <= 1'b0;
      case (state)
        IDLE: begin
          currency_inserted <= 1'b0;
          currency_amount   <= 8'd0;
          change_amount     <= 8'd0;
          refund_amount     <= 9'd0;
          note_reject       <= note_valid;
          if (collect_start && bill_amount != 8'd0) begin
            target           <= bill_amount;
            collected_amount <= 9'd0;
            timeout_cnt      <= '0;
            busy             <= 1'b1;
            state            <= COLLECT;
          end
        end
        COLLECT: begin
          note_reject <= note_valid && !code_ok;
          if (accept) begin
            collected_amount <= note_sum;
            timeout_cnt      <= '0;
          end
          // Cancel wins over settlement; a same-cycle note still lands in the refund.
          if (collect_cancel) begin
            refund_valid  <= 1'b1;
            refund_amount <= note_sum;
            state         <= REFUND;
          end else if (accept && note_sum >= {1'b0, target}) begin
            currency_inserted <= 1'b1;
            currency_amount   <= target;
            change_amount     <= change;
            hold_cnt          <= HW'(1);
            state             <= SETTLE;
          end else if (!accept) begin
            if (timeout_cnt == TIMEOUT_LAST) begin
              refund_valid  <= 1'b1;
              refund_amount <= collected_amount;
              state         <= REFUND;
            end else begin
              timeout_cnt <= timeout_cnt + TW'(1);
            end
          end
        end
        SETTLE: begin
          note_reject <= note_valid;
          if (hold_cnt >= HOLD_LAST) begin
            currency_inserted <= 1'b0;
            currency_amount   <= 8'd0;
            change_amount     <= 8'd0;
            hold_cnt          <= '0;
            busy              <= 1'b0;
            state             <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        REFUND: begin
          note_reject   <= note_valid;
          refund_amount <= 9'd0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_currency_note_collector.sv
// Directed test-plan steps followed by randomized transactions, each checked against a
// transaction-level model of note values, settlement, change and timeout refund.
module tb_currency_note_collector;

  localparam int HOLD    = 2;
  localparam int TIMEOUT = 40;

  logic       clk;
  logic       reset_n;
  logic       collect_start;
  logic [7:0] bill_amount;
  logic       note_valid;
  logic [3:0] note_code;
  logic       collect_cancel;
  logic       currency_inserted;
  logic [7:0] currency_amount;
  logic [7:0] change_amount;
  logic       refund_valid;
  logic [8:0] refund_amount;
  logic       note_reject;
  logic       busy;
  logic [8:0] collected_amount;

  int checks   = 0;
  int failures = 0;

  logic [3:0] valid_codes [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1010, 4'b0110, 4'b0000};
  logic [3:0] txn_code [8];
  int         txn_gap  [8];
  int         txn_n;
  int         txn_cancel;

  currency_note_collector #(
    .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .collect_start(collect_start),
    .bill_amount(bill_amount),
    .note_valid(note_valid),
    .note_code(note_code),
    .collect_cancel(collect_cancel),
    .currency_inserted(currency_inserted),
    .currency_amount(currency_amount),
    .change_amount(change_amount),
    .refund_valid(refund_valid),
    .refund_amount(refund_amount),
    .note_reject(note_reject),
    .busy(busy),
    .collected_amount(collected_amount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int units(input logic [3:0] c);
    case (c)
      4'b1000: return 200;
      4'b0100: return 100;
      4'b0010: return 20;
      4'b0001: return 10;
      4'b1010: return 4;
      4'b0110: return 2;
      4'b0000: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] randomCode();
    logic [3:0] c;
    if ($urandom_range(0, 7) == 0) begin
      do c = 4'($urandom_range(0, 15)); while (units(c) >= 0);
      return c;
    end
    return valid_codes[$urandom_range(0, 6)];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read right after the next edge.
  task automatic applyStimulus(input bit start, input logic [7:0] bill, input bit nv,
                               input logic [3:0] code, input bit cancel);
    collect_start  = start;
    bill_amount    = bill;
    note_valid     = nv;
    note_code      = code;
    collect_cancel = cancel;
    @(posedge clk);
    #1;
    collect_start  = 1'b0;
    note_valid     = 1'b0;
    collect_cancel = 1'b0;
  endtask

  task automatic refundExit();
    bit inj;
    inj = 1'($urandom_range(0, 1));
    applyStimulus(1'b0, 8'd0, inj, randomCode(), 1'b0);
    checkOutput("refund_end_valid", refund_valid, 0);
    checkOutput("refund_end_busy", busy, 0);
    checkOutput("refund_note_reject", note_reject, inj);
  endtask

  task automatic settleCheck(input int bill, input int total);
    bit inj;
    checkOutput("settle_inserted", currency_inserted, 1);
    checkOutput("settle_amount", currency_amount, bill);
    checkOutput("settle_change", change_amount, total - bill);
    checkOutput("settle_busy", busy, 1);
    for (int h = 1; h < HOLD; h++) begin
      inj = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 8'd0, inj, randomCode(), 1'($urandom_range(0, 1)));
      checkOutput("hold_inserted", currency_inserted, 1);
      checkOutput("hold_amount", currency_amount, bill);
      checkOutput("hold_note_reject", note_reject, inj);
      checkOutput("hold_no_refund", refund_valid, 0);
    end
    inj = 1'($urandom_range(0, 1));
    applyStimulus(1'b0, 8'd0, inj, randomCode(), 1'($urandom_range(0, 1)));
    checkOutput("post_settle_inserted", currency_inserted, 0);
    checkOutput("post_settle_busy", busy, 0);
    checkOutput("post_settle_amount", currency_amount, 0);
    checkOutput("post_settle_change", change_amount, 0);
    checkOutput("post_settle_reject", note_reject, inj);
    checkOutput("post_settle_refund", refund_valid, 0);
  endtask

  // One transaction from the txn_* arrays: settle, cancel or time out per the model.
  task automatic runTxn(input int bill);
    int  total, idle, v;
    bit  done;
    total = 0;
    idle  = 0;
    done  = 1'b0;
    applyStimulus(1'b1, 8'(bill), 1'b0, 4'd0, 1'b0);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_collected", collected_amount, 0);
    for (int i = 0; i < txn_n && !done; i++) begin
      for (int g = 0; g < txn_gap[i]; g++) begin
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), 1'b0, 4'd0, 1'b0);
        idle++;
        checkOutput("gap_collected", collected_amount, total);
        checkOutput("gap_busy", busy, 1);
      end
      applyStimulus(1'b0, 8'd0, 1'b1, txn_code[i], i == txn_cancel);
      v = units(txn_code[i]);
      if (v < 0) begin
        idle++;
        checkOutput("reject_invalid", note_reject, 1);
      end else begin
        idle = 0;
        total += v;
        checkOutput("accept_no_reject", note_reject, 0);
      end
      checkOutput("collected", collected_amount, total);
      if (i == txn_cancel) begin
        checkOutput("cancel_refund_valid", refund_valid, 1);
        checkOutput("cancel_refund_amount", refund_amount, total);
        checkOutput("cancel_no_insert", currency_inserted, 0);
        refundExit();
        done = 1'b1;
      end else if (v >= 0 && total >= bill) begin
        settleCheck(bill, total);
        done = 1'b1;
      end else begin
        checkOutput("collecting_busy", busy, 1);
        checkOutput("collecting_no_insert", currency_inserted, 0);
      end
    end
    if (!done) begin
      while (idle < TIMEOUT - 1) begin
        applyStimulus(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        idle++;
      end
      checkOutput("pre_timeout_refund", refund_valid, 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
      checkOutput("timeout_refund_valid", refund_valid, 1);
      checkOutput("timeout_refund_amount", refund_amount, total);
      checkOutput("timeout_no_insert", currency_inserted, 0);
      refundExit();
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    collect_start  = 1'b0;
    bill_amount    = 8'd0;
    note_valid     = 1'b0;
    note_code      = 4'd0;
    collect_cancel = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("reset_inserted", currency_inserted, 0);
    checkOutput("reset_amount", currency_amount, 0);
    checkOutput("reset_change", change_amount, 0);
    checkOutput("reset_refund_valid", refund_valid, 0);
    checkOutput("reset_refund_amount", refund_amount, 0);
    checkOutput("reset_reject", note_reject, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_collected", collected_amount, 0);
    reset_n = 1'b1;

    applyStimulus(1'b0, 8'd0, 1'b1, 4'b0001, 1'b0);
    checkOutput("idle_note_reject", note_reject, 1);
    checkOutput("idle_note_busy", busy, 0);

    // Test plan 1-4 and 6 as directed transactions with no idle gaps.
    txn_gap = '{0, 0, 0, 0, 0, 0, 0, 0};
    txn_n = 2; txn_cancel = -1; txn_code[0] = 4'b0010; txn_code[1] = 4'b0001;
    runTxn(30);
    txn_n = 1; txn_cancel = -1; txn_code[0] = 4'b0100;
    runTxn(15);
    txn_n = 2; txn_cancel = 1; txn_code[0] = 4'b0001; txn_code[1] = 4'b1010;
    runTxn(50);
    txn_n = 1; txn_cancel = -1; txn_code[0] = 4'b0011;
    runTxn(10);

    applyStimulus(1'b1, 8'd30, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 4'b0010, 1'b0);
    checkOutput("pre_reset_collected", collected_amount, 20);
    reset_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    reset_n = 1'b1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_collected", collected_amount, 0);
    checkOutput("midreset_refund", refund_valid, 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("midreset_no_late_refund", refund_valid, 0);
    applyStimulus(1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("zero_bill_busy", busy, 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    checkOutput("zero_bill_still_idle", busy, 0);

    txn_n = 1; txn_cancel = -1; txn_code[0] = 4'b0110;
    runTxn(2);
    txn_n = 1; txn_cancel = -1; txn_code[0] = 4'b1010;
    runTxn(4);

    for (int t = 0; t < 40; t++) begin
      int bill;
      bill = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 255));
      txn_n = $urandom_range(1, 8);
      for (int k = 0; k < 8; k++) begin
        txn_code[k] = randomCode();
        txn_gap[k]  = $urandom_range(0, 3);
      end
      txn_cancel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, txn_n - 1)) : -1;
      runTxn(bill);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
